// File: rtl/load_store_unit.sv
// Load/store unit for a byte-addressed 32-bit little-endian data memory.
// Takes one request at a time and checks its size, alignment and range.
// Sub-word stores use read-modify-write. Loads are extracted from the word
// and extended. Every output is a flop, loaded from the next-state decode.
module load_store_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read_sig,
  output logic        mem_wrt_sig
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int              CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [32:0]     MEM_END  = 33'(MEM_BYTES);

  // Number of bytes touched by an access of the given size code.
  function automatic logic [32:0] size_bytes(input logic [1:0] size);
    logic [32:0] n;
    case (size)
      2'd0:    n = 33'd1;
      2'd1:    n = 33'd2;
      default: n = 33'd4;
    endcase
    return n;
  endfunction

  // Illegal size, misalignment, or an access running past the end of memory.
  function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size);
    logic align_err;
    logic range_err;
    case (size)
      2'd0:    align_err = 1'b0;
      2'd1:    align_err = addr[0];
      2'd2:    align_err = (addr[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
    range_err = (({1'b0, addr} + size_bytes(size)) > MEM_END);
    return align_err | range_err;
  endfunction

  // Select the addressed byte/half lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      2'd0:    res = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    res = {{16{sgn & sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the right-justified store data onto the addressed lanes of a word.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      2'd0: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = wdata << {lane, 3'b000};
      end
      2'd1: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        data = wdata << {lane[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_wrt_q, mem_wrt_d;

  // Next-state, request capture and registered-output decode.
  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          signed_d   = req_signed;
          lane_d     = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[31:2], 2'b00};
          rd_cnt_d   = '0;
          if (req_error(req_addr, req_size)) begin
            state_d    = S_RESP;
            resp_err_d = 1'b1;
          end else if (!req_write || (req_size != 2'd2)) begin
            state_d = S_RD;
          end else begin
            state_d     = S_WR;
            mem_wdata_d = req_wdata;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (rd_cnt_q == CNT_LAST) begin
          if (write_q) begin
            state_d     = S_WR;
            mem_wdata_d = store_merge(mem_rdata, wdata_q, size_q, lane_q);
          end else begin
            state_d      = S_RESP;
            resp_rdata_d = load_extract(mem_rdata, size_q, lane_q, signed_q);
          end
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    mem_read_d   = (state_d == S_RD);
    mem_wrt_d    = (state_d == S_WR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_cnt_q     <= '0;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      lane_q       <= 2'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_read_q   <= 1'b0;
      mem_wrt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_wrt_q    <= mem_wrt_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_read_sig = mem_read_q;
  assign mem_wrt_sig  = mem_wrt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory and an
// expected-response queue.
module tb_load_store_unit;

  localparam int MEM_BYTES = 1024;
  localparam int READ_LAT  = 2;
  localparam int LAT_LD    = READ_LAT + 1;
  localparam int LAT_WST   = 2;
  localparam int LAT_SST   = READ_LAT + 2;
  localparam int LAT_ERR   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read_sig;
  logic        mem_wrt_sig;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read_sig(mem_read_sig), .mem_wrt_sig(mem_wrt_sig)
  );

  // Behavioural little-endian memory
  logic [7:0] mem [0:MEM_BYTES-1];
  assign mem_rdata = {mem[{mem_addr[9:2], 2'b11}], mem[{mem_addr[9:2], 2'b10}],
                      mem[{mem_addr[9:2], 2'b01}], mem[{mem_addr[9:2], 2'b00}]};
  always @(posedge clk) begin
    if (mem_wrt_sig) begin
      mem[{mem_addr[9:2], 2'b00}] <= mem_wdata[7:0];
      mem[{mem_addr[9:2], 2'b01}] <= mem_wdata[15:8];
      mem[{mem_addr[9:2], 2'b10}] <= mem_wdata[23:16];
      mem[{mem_addr[9:2], 2'b11}] <= mem_wdata[31:24];
    end
  end

  // Edge counter and strobe/response statistics
  int edge_cnt = 0;
  int rd_cyc = 0, wr_cyc = 0, rd_rise = 0, overlap = 0, resp_cnt = 0;
  logic rd_prev = 1'b0;
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rd_prev  <= mem_read_sig;
    if (mem_read_sig) rd_cyc <= rd_cyc + 1;
    if (mem_wrt_sig) wr_cyc <= wr_cyc + 1;
    if (mem_read_sig && !rd_prev) rd_rise <= rd_rise + 1;
    if (mem_read_sig && mem_wrt_sig) overlap <= overlap + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Issue one request (called at a negedge), wait for its response, compare.
  task automatic do_req(input string tag, input logic w, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    int n;
    int acc;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = lat;
    sb_q.push_back(e);
    req_valid = 1'b1; req_write = w; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    acc = edge_cnt + 1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    e = sb_q.pop_front();
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
    check({tag, "_latency"}, 32'(edge_cnt - acc + 1), 32'(e.lat));
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int wr0, rd0, resp0, rise0, n, accepts, resps;
    int acc_e [2];
    exp_t e;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_strobes", {30'd0, mem_read_sig, mem_wrt_sig}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset for two cycles in the middle of a byte-store RMW
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'd8; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_in_rd", {31'd0, mem_read_sig}, 32'd1);
    wr0 = wr_cyc; resp0 = resp_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_read_low", {31'd0, mem_read_sig}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", {31'd0, req_ready}, 32'd1);
    repeat (8) @(negedge clk);
    check("postrst_no_write", 32'(wr_cyc - wr0), 32'd0);
    check("postrst_no_resp", 32'(resp_cnt - resp0), 32'd0);
    check("postrst_mem8", mem_word(8), 32'd0);

    // 2: word store then word load
    wr0 = wr_cyc;
    do_req("st_w8", 1'b1, 2'd2, 1'b0, 32'd8, 32'hDEADBEEF, 32'd0, 1'b0, LAT_WST);
    check("st_w8_wr_cycles", 32'(wr_cyc - wr0), 32'd1);
    check("st_w8_mem", mem_word(8), 32'hDEADBEEF);
    do_req("ld_w8", 1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 32'hDEADBEEF, 1'b0, LAT_LD);

    // 3: byte store over the word, then byte/half loads
    wr0 = wr_cyc;
    do_req("st_b9", 1'b1, 2'd0, 1'b0, 32'd9, 32'hFFFFFF80, 32'd0, 1'b0, LAT_SST);
    check("st_b9_wr_cycles", 32'(wr_cyc - wr0), 32'd1);
    check("st_b9_mem", mem_word(8), 32'hDEAD80EF);
    do_req("ld_b9_s", 1'b0, 2'd0, 1'b1, 32'd9, 32'd0, 32'hFFFFFF80, 1'b0, LAT_LD);
    do_req("ld_b9_u", 1'b0, 2'd0, 1'b0, 32'd9, 32'd0, 32'h00000080, 1'b0, LAT_LD);
    do_req("ld_b8_s", 1'b0, 2'd0, 1'b1, 32'd8, 32'd0, 32'hFFFFFFEF, 1'b0, LAT_LD);
    do_req("ld_b11_u", 1'b0, 2'd0, 1'b0, 32'd11, 32'd0, 32'h000000DE, 1'b0, LAT_LD);
    do_req("ld_h8_u", 1'b0, 2'd1, 1'b0, 32'd8, 32'd0, 32'h000080EF, 1'b0, LAT_LD);
    do_req("ld_h8_s", 1'b0, 2'd1, 1'b1, 32'd8, 32'd0, 32'hFFFF80EF, 1'b0, LAT_LD);

    // 4: half store into the upper lanes of a fresh word
    do_req("st_w8b", 1'b1, 2'd2, 1'b0, 32'd8, 32'hDEADBEEF, 32'd0, 1'b0, LAT_WST);
    do_req("st_h10", 1'b1, 2'd1, 1'b0, 32'd10, 32'hABCD1234, 32'd0, 1'b0, LAT_SST);
    check("st_h10_mem", mem_word(8), 32'h1234BEEF);
    do_req("ld_h10_s", 1'b0, 2'd1, 1'b1, 32'd10, 32'd0, 32'h00001234, 1'b0, LAT_LD);
    do_req("ld_h8_s2", 1'b0, 2'd1, 1'b1, 32'd8, 32'd0, 32'hFFFFBEEF, 1'b0, LAT_LD);

    // 5: error cases make no memory access; legal accesses at the top edge
    rd0 = rd_cyc; wr0 = wr_cyc;
    do_req("err_w6", 1'b0, 2'd2, 1'b0, 32'd6, 32'd0, 32'd0, 1'b1, LAT_ERR);
    do_req("err_h3", 1'b0, 2'd1, 1'b1, 32'd3, 32'd0, 32'd0, 1'b1, LAT_ERR);
    do_req("err_sz3", 1'b0, 2'd3, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, LAT_ERR);
    do_req("err_w1022", 1'b0, 2'd2, 1'b0, 32'd1022, 32'd0, 32'd0, 1'b1, LAT_ERR);
    do_req("err_b1024", 1'b0, 2'd0, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1, LAT_ERR);
    do_req("err_st_w2", 1'b1, 2'd2, 1'b0, 32'd2, 32'h12345678, 32'd0, 1'b1, LAT_ERR);
    check("err_no_read", 32'(rd_cyc - rd0), 32'd0);
    check("err_no_write", 32'(wr_cyc - wr0), 32'd0);
    check("err_mem0", mem_word(0), 32'd0);
    do_req("st_w1020", 1'b1, 2'd2, 1'b0, 32'd1020, 32'hC0FFEE11, 32'd0, 1'b0, LAT_WST);
    do_req("st_b1023", 1'b1, 2'd0, 1'b0, 32'd1023, 32'h000000A5, 32'd0, 1'b0, LAT_SST);
    do_req("ld_w1020", 1'b0, 2'd2, 1'b0, 32'd1020, 32'd0, 32'hA5FFEE11, 1'b0, LAT_LD);
    do_req("ld_h1022_s", 1'b0, 2'd1, 1'b1, 32'd1022, 32'd0, 32'hFFFFA5FF, 1'b0, LAT_LD);

    // 6: back-to-back loads with req_valid held high
    e.rdata = 32'h1234BEEF; e.err = 1'b0; e.lat = LAT_LD;
    sb_q.push_back(e);
    e.rdata = 32'h00001234;
    sb_q.push_back(e);
    rise0 = rd_rise;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'd8;
    accepts = 0; resps = 0; n = 0;
    while ((accepts < 2 || resps < 2) && n < 40) begin
      if (resp_valid) begin
        e = sb_q.pop_front();
        check("b2b_rdata", resp_rdata, e.rdata);
        check("b2b_err", {31'd0, resp_err}, 32'd0);
        resps++;
      end
      if (req_valid && req_ready) begin
        acc_e[accepts] = edge_cnt + 1;
        accepts++;
      end
      @(negedge clk);
      if (accepts == 1) begin
        req_size = 2'd1; req_addr = 32'd10;
      end else if (accepts == 2) begin
        req_valid = 1'b0;
      end
      n++;
    end
    check("b2b_accepts", 32'(accepts), 32'd2);
    check("b2b_resps", 32'(resps), 32'd2);
    check("b2b_spacing", 32'(acc_e[1] - acc_e[0]), 32'(READ_LAT + 2));
    @(negedge clk);
    check("b2b_read_edges", 32'(rd_rise - rise0), 32'd2);

    check("strobe_overlap", 32'(overlap), 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
